sync_down_counter: RTL and testbench
====================================

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, counter and load-value width (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: load  input  1  load request, sampled on rising clk.
REQ-005 SHALL have port: load_val  input  WIDTH  start/reload value, captured when load=1.
REQ-006 SHALL have port: en  input  1  count enable.
REQ-007 SHALL have port: mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle.
REQ-008 SHALL have port: q  output  WIDTH  current count, registered.
REQ-009 SHALL have port: tc  output  1  terminal-count pulse, registered.
REQ-010 SHALL have port: busy  output  1  high while state = RUN.
REQ-011 SHALL have port: done  output  1  high while state = DONE.

Function
REQ-012 SHALL be fully synchronous to clk: no derived or gated clocks, no ripple stages.
REQ-013 SHALL implement a three-state FSM, IDLE, RUN, DONE, with busy and done decoded from state.
REQ-014 SHALL give load top priority in every state: q <= load_val, reload_reg <= load_val, tc <= 0 next cycle, regardless of en or mode.
REQ-015 SHALL, on load with load_val != 0, enter RUN next cycle; with load_val == 0, enter IDLE with q = 0 and no tc.
REQ-016 SHALL, in RUN with en=1 and q > 1, decrement q by 1 per cycle.
REQ-017 SHALL, in RUN with en=1 and q == 1, set q <= 0 and tc <= 1; next state DONE if mode=0, else RUN.
REQ-018 SHALL, in RUN with en=1, q == 0 and mode=1, reload q <= reload_reg with tc <= 0; reload period is reload_reg+1 enabled cycles.
REQ-019 SHALL, in RUN with en=1, q == 0 and mode=0 (mode changed mid-run), enter DONE and hold q = 0 with no extra tc.
REQ-020 SHALL hold q, state and reload_reg when en=0 and load=0; tc SHALL be 0 in that cycle.
REQ-021 SHALL assert tc for exactly one clk cycle per 1->0 transition of q; tc high coincides with the first cycle q reads 0.
REQ-022 SHALL never wrap q from 0 to all-ones; decrement below 0 is impossible in every state.
REQ-023 SHALL, in IDLE or DONE, ignore en; q holds until load.
REQ-024 SHALL, on load during RUN (mid-count restart), discard the current count and suppress any tc that would have fired that cycle.

Reset
REQ-025 SHALL, while rst_n = 0, force immediately (without clk): q = 0, tc = 0, reload_reg = 0, state = IDLE, busy = 0, done = 0.
REQ-026 SHALL, on rst_n assertion mid-count, abandon the count with no tc pulse; first action after release requires load.
REQ-027 SHALL ignore load and en in the cycle rst_n is low; first active edge after rst_n rises SHALL process inputs normally.

Verification
REQ-028 SHALL pass one-shot: load_val=5, mode=0, en=1 steady -> q 5,4,3,2,1,0; tc high one cycle with q=0; done=1, busy=0 thereafter, q stays 0.
REQ-029 SHALL pass auto-reload: load_val=3, mode=1, en=1 for 12 cycles -> q 3,2,1,0,3,2,1,0,...; tc pulses every 4 cycles; busy stays 1.
REQ-030 SHALL pass enable gating: load_val=4, en toggled 1,0,0,1,1 -> q 4,3,3,3,2,1; tc=0 throughout; no change while en=0.
REQ-031 SHALL pass mid-count reload: load_val=9, count to q=6, load with load_val=2 while en=1 -> q=2 next cycle, then 1,0 with single tc.
REQ-032 SHALL pass async reset: rst_n low between clk edges at q=5 in RUN -> q=0, busy=0, tc=0 immediately; after release, en=1 without load -> q stays 0.
REQ-033 SHALL pass boundaries: load_val=0 -> IDLE, q=0, no tc; load_val=all-ones (15 at WIDTH=4) one-shot -> 16 cycles to q=0, single tc, no wrap.

Source files
------------

// File: rtl/sync_down_counter.sv
// ----------------------------------------------------------------------------
// sync_down_counter
// Loadable synchronous down counter with one-shot and auto-reload modes.
// A load starts a count from load_val; the counter steps down on each enabled
// cycle and pulses tc for one cycle when q goes from 1 to 0. In one-shot mode
// the FSM then parks in DONE. In auto-reload mode it reloads the last loaded
// value on the next enabled cycle.
//
// Ports
//   clk      : clock, all state updates on rising edge
//   rst_n    : asynchronous active-low reset
//   load     : load request (top priority)
//   load_val : start / reload value, captured when load=1
//   en       : count enable (ignored outside RUN)
//   mode     : 0 = one-shot, 1 = auto-reload, sampled every cycle
//   q        : current count (registered)
//   tc       : terminal-count pulse (registered)
//   busy     : high while in RUN
//   done     : high while in DONE
// ----------------------------------------------------------------------------
module sync_down_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;

   // State, count, reload value and tc registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   // Next-state logic; load overrides everything, tc defaults low
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         // A zero load has nothing to count, so it parks in IDLE
         state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (en) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else if (count_q == WIDTH'(1)) begin
                     count_d = '0;
                     tc_d    = 1'b1;
                     state_d = mode ? ST_RUN : ST_DONE;
                  end else if (mode) begin
                     // Reload costs one enabled cycle at zero: period = reload+1
                     count_d = reload_q;
                  end else begin
                     // Mode dropped to one-shot while sitting at zero
                     state_d = ST_DONE;
                  end
               end
            end
            ST_IDLE, ST_DONE: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   assign q    = count_q;
   assign tc   = tc_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_sync_down_counter.sv
// ----------------------------------------------------------------------------
// tb_sync_down_counter
// Directed scenarios for sync_down_counter (WIDTH=4). Each driven cycle pushes
// the expected {q, tc, busy, done} into a scoreboard queue; the entry is
// popped and compared just after the following rising edge.
// ----------------------------------------------------------------------------
module tb_sync_down_counter;

   localparam int unsigned WIDTH = 4;

   typedef struct {
      int unsigned q;
      int unsigned tc;
      int unsigned busy;
      int unsigned done;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             mode;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;
   logic             done;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   sync_down_counter #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .mode     (mode),
      .q        (q),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int unsigned eq, input int unsigned etc,
                           input int unsigned eb, input int unsigned ed);
      exp_t e;
      e.q = eq; e.tc = etc; e.busy = eb; e.done = ed;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, " sb_empty"}, 1, 0);
      end else begin
         e = sb_q.pop_front();
         check({tag, " q"},    int'(q),    e.q);
         check({tag, " tc"},   int'(tc),   e.tc);
         check({tag, " busy"}, int'(busy), e.busy);
         check({tag, " done"}, int'(done), e.done);
      end
   endtask

   // Drive one cycle of inputs, expect the given outputs after the edge
   task automatic step(input string tag, input logic ld, input int unsigned lv,
                       input logic e, input logic m,
                       input int unsigned eq, input int unsigned etc,
                       input int unsigned eb, input int unsigned ed);
      @(negedge clk);
      load     = ld;
      load_val = WIDTH'(lv);
      en       = e;
      mode     = m;
      push_exp(eq, etc, eb, ed);
      @(posedge clk);
      #1;
      pop_cmp(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; mode = 1'b0;
      #12;
      push_exp(0, 0, 0, 0);
      pop_cmp("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // One-shot from 5
      step("os_load", 1, 5, 1, 0, 5, 0, 1, 0);
      for (int i = 4; i >= 1; i--) step("os_cnt", 0, 0, 1, 0, i, 0, 1, 0);
      step("os_tc", 0, 0, 1, 0, 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) step("os_hold", 0, 0, 1, 0, 0, 0, 0, 1);

      // Auto-reload from 3: 12 enabled cycles
      step("ar_load", 1, 3, 1, 1, 3, 0, 1, 0);
      for (int i = 1; i <= 12; i++) begin
         int unsigned eq;
         eq = 3 - (i % 4);
         step("ar_cnt", 0, 0, 1, 1, eq, (eq == 0) ? 1 : 0, 1, 0);
      end
      // Now at 3; count to zero, then drop mode at zero
      step("ar_m", 0, 0, 1, 1, 2, 0, 1, 0);
      step("ar_m", 0, 0, 1, 1, 1, 0, 1, 0);
      step("ar_m", 0, 0, 1, 1, 0, 1, 1, 0);
      step("ar_mode0", 0, 0, 1, 0, 0, 0, 0, 1);
      step("ar_mode0_hold", 0, 0, 1, 1, 0, 0, 0, 1);

      // Enable gating from 4
      step("eg_load", 1, 4, 0, 0, 4, 0, 1, 0);
      step("eg_1", 0, 0, 1, 0, 3, 0, 1, 0);
      step("eg_0", 0, 0, 0, 0, 3, 0, 1, 0);
      step("eg_0", 0, 0, 0, 1, 3, 0, 1, 0);
      step("eg_1", 0, 0, 1, 0, 2, 0, 1, 0);
      step("eg_1", 0, 0, 1, 0, 1, 0, 1, 0);
      step("eg_0_at1", 0, 0, 0, 0, 1, 0, 1, 0);
      step("eg_end", 0, 0, 1, 0, 0, 1, 0, 1);

      // Mid-count reload 9 -> 2
      step("mc_load", 1, 9, 1, 0, 9, 0, 1, 0);
      for (int i = 8; i >= 6; i--) step("mc_cnt", 0, 0, 1, 0, i, 0, 1, 0);
      step("mc_reload", 1, 2, 1, 0, 2, 0, 1, 0);
      step("mc_cnt", 0, 0, 1, 0, 1, 0, 1, 0);
      step("mc_tc", 0, 0, 1, 0, 0, 1, 0, 1);
      step("mc_post", 0, 0, 1, 0, 0, 0, 0, 1);

      // Load at q=1 suppresses the tc that would have fired
      step("sup_load", 1, 2, 1, 1, 2, 0, 1, 0);
      step("sup_cnt", 0, 0, 1, 1, 1, 0, 1, 0);
      step("sup_reload", 1, 5, 1, 1, 5, 0, 1, 0);

      // Boundaries: zero load, all-ones one-shot
      step("b0_load", 1, 0, 1, 0, 0, 0, 0, 0);
      step("b0_idle", 0, 0, 1, 1, 0, 0, 0, 0);
      step("b15_load", 1, 15, 1, 0, 15, 0, 1, 0);
      for (int i = 14; i >= 1; i--) step("b15_cnt", 0, 0, 1, 0, i, 0, 1, 0);
      step("b15_tc", 0, 0, 1, 0, 0, 1, 0, 1);
      step("b15_nowrap", 0, 0, 1, 0, 0, 0, 0, 1);
      step("b15_nowrap", 0, 0, 1, 1, 0, 0, 0, 1);

      // Asynchronous reset mid-count, between edges
      step("ar_rst_load", 1, 6, 1, 0, 6, 0, 1, 0);
      step("ar_rst_cnt", 0, 0, 1, 0, 5, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      push_exp(0, 0, 0, 0);
      pop_cmp("async_rst");
      @(negedge clk);
      load = 1'b1; load_val = WIDTH'(7); en = 1'b1;
      push_exp(0, 0, 0, 0);
      @(posedge clk);
      #1;
      pop_cmp("rst_ignores_load");
      #2;
      rst_n = 1'b1;
      step("post_rst_en", 0, 0, 1, 0, 0, 0, 0, 0);
      step("post_rst_en", 0, 0, 1, 1, 0, 0, 0, 0);
      step("post_rst_load", 1, 2, 1, 0, 2, 0, 1, 0);
      step("post_rst_cnt", 0, 0, 1, 0, 1, 0, 1, 0);
      step("post_rst_tc", 0, 0, 1, 0, 0, 1, 0, 1);

      check("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
